// File: rtl/rx_result_writer.sv
`default_nettype none
// ============================================================================
//  Module   : rx_result_writer
//  Purpose  : Write-side sequencer for the RX result RAM. Accepts a
//             valid/ready stream of results and writes each word to the next
//             RAM address through the arithmetic write port. A run starts at
//             a programmed base address and covers a programmed word count.
//             The block reports busy/done status, the number of words written
//             and a sticky drop error.
//  Ports    : ram_clock, reset          - clock and asynchronous active-high reset
//             start, base_addr, length  - run control, sampled on an accepted start
//             abort                     - ends a run that is in progress
//             in_valid, in_data,
//             in_ready                  - result stream
//             we_arith, addr_arith,
//             data_arith                - registered RAM write port
//             busy, done, words_written,
//             drop_err                  - status for the HPS
//  Revision : 1.0  initial release
// ============================================================================
module rx_result_writer #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  ram_clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic                  abort,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  we_arith,
   output logic [ADDR_WIDTH-1:0] addr_arith,
   output logic [DATA_WIDTH-1:0] data_arith,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   words_written,
   output logic                  drop_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH:0] c_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH:0]   r_remaining;
   logic [ADDR_WIDTH:0]   r_words_written;
   logic                  r_drop_err;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;

   logic w_ready;
   logic w_xfer;
   logic w_start_acc;
   logic w_drop;

   // start is only honoured outside RUN, so a start/abort collision resolves
   // to "abort wins in RUN, start wins elsewhere" without extra logic.
   assign w_ready     = (r_state == ST_RUN) && !abort;
   assign w_xfer      = in_valid && w_ready;
   assign w_start_acc = start && (r_state != ST_RUN);
   assign w_drop      = in_valid && !w_ready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_start_acc) begin
               w_state_nxt = (length != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_xfer && (r_remaining == c_one)) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ram_clock or posedge reset) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_ptr           <= '0;
         r_remaining     <= '0;
         r_words_written <= '0;
         r_drop_err      <= 1'b0;
         r_we            <= 1'b0;
         r_addr          <= '0;
         r_data          <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_we    <= w_xfer;

         if (w_start_acc) begin
            r_ptr           <= base_addr;
            r_remaining     <= length;
            r_words_written <= '0;
         end else if (w_xfer) begin
            r_ptr           <= r_ptr + 1'b1;   // wraps modulo the address space
            r_remaining     <= r_remaining - c_one;
            r_words_written <= r_words_written + c_one;
         end

         if (w_xfer) begin
            r_addr <= r_ptr;
            r_data <= in_data;
         end

         // A word dropped in the same cycle a start is accepted is still a
         // lost word, so setting the flag takes priority over clearing it.
         if (w_drop) begin
            r_drop_err <= 1'b1;
         end else if (w_start_acc) begin
            r_drop_err <= 1'b0;
         end
      end
   end

   assign in_ready      = w_ready;
   assign we_arith      = r_we;
   assign addr_arith    = r_addr;
   assign data_arith    = r_data;
   assign busy          = (r_state == ST_RUN);
   assign done          = (r_state == ST_DONE);
   assign words_written = r_words_written;
   assign drop_err      = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_rx_result_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_result_writer
//  Purpose  : Self-checking bench for rx_result_writer: per-cycle vector
//             table plus hand-written full-length and mid-run reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rx_result_writer;

   localparam int AW = 11;
   localparam int DW = 32;

   logic          ram_clock = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          abort;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          we_arith;
   logic [AW-1:0] addr_arith;
   logic [DW-1:0] data_arith;
   logic          busy;
   logic          done;
   logic [AW:0]   words_written;
   logic          drop_err;

   int n_checks = 0;
   int n_errors = 0;

   rx_result_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .ram_clock     (ram_clock),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .length        (length),
      .abort         (abort),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .we_arith      (we_arith),
      .addr_arith    (addr_arith),
      .data_arith    (data_arith),
      .busy          (busy),
      .done          (done),
      .words_written (words_written),
      .drop_err      (drop_err)
   );

   always #5 ram_clock = ~ram_clock;

   typedef struct {
      logic          st;
      logic [AW-1:0] base;
      logic [AW:0]   len;
      logic          ab;
      logic          vl;
      logic [DW-1:0] din;
      logic          e_rdy;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      logic          e_busy;
      logic          e_done;
      logic [AW:0]   e_ww;
      logic          e_drop;
   } vec_t;

   localparam int NV = 34;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic st, input logic [AW-1:0] base, input logic [AW:0] len,
      input logic ab, input logic vl, input logic [DW-1:0] din,
      input logic rdy, input logic we, input logic [AW-1:0] addr,
      input logic [DW-1:0] data, input logic bsy, input logic dn,
      input logic [AW:0] ww, input logic drp);
      vec_t v;
      v.st = st; v.base = base; v.len = len; v.ab = ab; v.vl = vl; v.din = din;
      v.e_rdy = rdy; v.e_we = we; v.e_addr = addr; v.e_data = data;
      v.e_busy = bsy; v.e_done = dn; v.e_ww = ww; v.e_drop = drp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_outputs(input string tag, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic bsy, input logic dn,
                              input logic [AW:0] ww, input logic drp);
      chk({tag, ".we_arith"},      {31'd0, we_arith},      {31'd0, we});
      chk({tag, ".addr_arith"},    {21'd0, addr_arith},    {21'd0, addr});
      chk({tag, ".data_arith"},    data_arith,             data);
      chk({tag, ".busy"},          {31'd0, busy},          {31'd0, bsy});
      chk({tag, ".done"},          {31'd0, done},          {31'd0, dn});
      chk({tag, ".words_written"}, {20'd0, words_written}, {20'd0, ww});
      chk({tag, ".drop_err"},      {31'd0, drop_err},      {31'd0, drp});
   endtask

   task automatic idle_inputs();
      start = 1'b0; base_addr = '0; length = '0; abort = 1'b0;
      in_valid = 1'b0; in_data = '0;
   endtask

   initial begin
      // ---------------------------------------------------------------- table
      vecs[0]  = mk(1, 11'h010, 12'd4, 0, 0, 32'h0,  0, 0, 11'h013 & 11'h0, 32'h0,  1, 0, 12'd0, 0);
      vecs[1]  = mk(0, 11'h0,   12'd0, 0, 1, 32'hA0, 1, 1, 11'h010, 32'hA0, 1, 0, 12'd1, 0);
      vecs[2]  = mk(0, 11'h0,   12'd0, 0, 1, 32'hA1, 1, 1, 11'h011, 32'hA1, 1, 0, 12'd2, 0);
      vecs[3]  = mk(0, 11'h0,   12'd0, 0, 1, 32'hA2, 1, 1, 11'h012, 32'hA2, 1, 0, 12'd3, 0);
      vecs[4]  = mk(0, 11'h0,   12'd0, 0, 1, 32'hA3, 1, 1, 11'h013, 32'hA3, 0, 1, 12'd4, 0);
      vecs[5]  = mk(0, 11'h0,   12'd0, 0, 0, 32'h0,  0, 0, 11'h013, 32'hA3, 0, 1, 12'd4, 0);
      // wrap, started back-to-back from DONE
      vecs[6]  = mk(1, 11'h7FE, 12'd4, 0, 0, 32'h0,  0, 0, 11'h013, 32'hA3, 1, 0, 12'd0, 0);
      vecs[7]  = mk(0, 11'h0,   12'd0, 0, 1, 32'hB0, 1, 1, 11'h7FE, 32'hB0, 1, 0, 12'd1, 0);
      vecs[8]  = mk(0, 11'h0,   12'd0, 0, 1, 32'hB1, 1, 1, 11'h7FF, 32'hB1, 1, 0, 12'd2, 0);
      vecs[9]  = mk(0, 11'h0,   12'd0, 0, 1, 32'hB2, 1, 1, 11'h000, 32'hB2, 1, 0, 12'd3, 0);
      vecs[10] = mk(0, 11'h0,   12'd0, 0, 1, 32'hB3, 1, 1, 11'h001, 32'hB3, 0, 1, 12'd4, 0);
      vecs[11] = mk(0, 11'h0,   12'd0, 0, 0, 32'h0,  0, 0, 11'h001, 32'hB3, 0, 1, 12'd4, 0);
      // gaps in in_valid
      vecs[12] = mk(1, 11'h100, 12'd3, 0, 0, 32'h0,  0, 0, 11'h001, 32'hB3, 1, 0, 12'd0, 0);
      vecs[13] = mk(0, 11'h0,   12'd0, 0, 1, 32'hC0, 1, 1, 11'h100, 32'hC0, 1, 0, 12'd1, 0);
      vecs[14] = mk(0, 11'h0,   12'd0, 0, 0, 32'h0,  1, 0, 11'h100, 32'hC0, 1, 0, 12'd1, 0);
      vecs[15] = mk(0, 11'h0,   12'd0, 0, 1, 32'hC1, 1, 1, 11'h101, 32'hC1, 1, 0, 12'd2, 0);
      vecs[16] = mk(0, 11'h0,   12'd0, 0, 0, 32'h0,  1, 0, 11'h101, 32'hC1, 1, 0, 12'd2, 0);
      vecs[17] = mk(0, 11'h0,   12'd0, 0, 1, 32'hC2, 1, 1, 11'h102, 32'hC2, 0, 1, 12'd3, 0);
      vecs[18] = mk(0, 11'h0,   12'd0, 0, 0, 32'h0,  0, 0, 11'h102, 32'hC2, 0, 1, 12'd3, 0);
      // abort after 3 transfers with in_valid still high
      vecs[19] = mk(1, 11'h200, 12'd8, 0, 0, 32'h0,  0, 0, 11'h102, 32'hC2, 1, 0, 12'd0, 0);
      vecs[20] = mk(0, 11'h0,   12'd0, 0, 1, 32'hD0, 1, 1, 11'h200, 32'hD0, 1, 0, 12'd1, 0);
      vecs[21] = mk(0, 11'h0,   12'd0, 0, 1, 32'hD1, 1, 1, 11'h201, 32'hD1, 1, 0, 12'd2, 0);
      vecs[22] = mk(0, 11'h0,   12'd0, 0, 1, 32'hD2, 1, 1, 11'h202, 32'hD2, 1, 0, 12'd3, 0);
      vecs[23] = mk(0, 11'h0,   12'd0, 1, 1, 32'hD3, 0, 0, 11'h202, 32'hD2, 0, 0, 12'd3, 1);
      vecs[24] = mk(0, 11'h0,   12'd0, 1, 0, 32'h0,  0, 0, 11'h202, 32'hD2, 0, 0, 12'd3, 1);
      // start+abort in IDLE: start wins; length 0 goes straight to DONE
      vecs[25] = mk(1, 11'h300, 12'd0, 1, 0, 32'h0,  0, 0, 11'h202, 32'hD2, 0, 1, 12'd0, 0);
      // start mid-run ignored
      vecs[26] = mk(1, 11'h010, 12'd2, 0, 0, 32'h0,  0, 0, 11'h202, 32'hD2, 1, 0, 12'd0, 0);
      vecs[27] = mk(0, 11'h0,   12'd0, 0, 1, 32'hE0, 1, 1, 11'h010, 32'hE0, 1, 0, 12'd1, 0);
      vecs[28] = mk(1, 11'h500, 12'd5, 0, 1, 32'hE1, 1, 1, 11'h011, 32'hE1, 0, 1, 12'd2, 0);
      // start+abort in RUN: abort wins
      vecs[29] = mk(1, 11'h400, 12'd3, 0, 0, 32'h0,  0, 0, 11'h011, 32'hE1, 1, 0, 12'd0, 0);
      vecs[30] = mk(1, 11'h600, 12'd7, 1, 0, 32'h0,  0, 0, 11'h011, 32'hE1, 0, 0, 12'd0, 0);
      // word offered in IDLE is dropped
      vecs[31] = mk(0, 11'h0,   12'd0, 0, 1, 32'h77, 0, 0, 11'h011, 32'hE1, 0, 0, 12'd0, 1);
      // length 1 run clears the drop flag
      vecs[32] = mk(1, 11'h000, 12'd1, 0, 0, 32'h0,  0, 0, 11'h011, 32'hE1, 1, 0, 12'd0, 0);
      vecs[33] = mk(0, 11'h0,   12'd0, 0, 1, 32'h99, 1, 1, 11'h000, 32'h99, 0, 1, 12'd1, 0);

      // ---------------------------------------------------------------- reset
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge ram_clock);
      #1 reset = 1'b0;
      chk_outputs("reset", 0, 11'h0, 32'h0, 0, 0, 12'd0, 0);
      chk("reset.in_ready", {31'd0, in_ready}, 32'd0);

      // ---------------------------------------------------------------- vectors
      for (int i = 0; i < NV; i++) begin
         start = vecs[i].st; base_addr = vecs[i].base; length = vecs[i].len;
         abort = vecs[i].ab; in_valid = vecs[i].vl; in_data = vecs[i].din;
         #1;
         chk($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
         @(posedge ram_clock);
         #1;
         chk_outputs($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data,
                     vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ww, vecs[i].e_drop);
      end

      // ---------------------------------------------------------------- full 2048-word run
      begin
         bit     seen [2048];
         int     bad_addr = 0;
         int     dup = 0;
         logic [AW-1:0] exp_a;
         idle_inputs();
         start = 1'b1; base_addr = 11'h123; length = 12'd2048;
         @(posedge ram_clock);
         #1;
         chk("full.busy_after_start", {31'd0, busy}, 32'd1);
         idle_inputs();
         in_valid = 1'b1;
         in_data  = 32'd0;
         for (int i = 0; i < 2048; i++) begin
            @(posedge ram_clock);
            #1;
            exp_a = 11'h123 + i[AW-1:0];
            if (we_arith !== 1'b1 || addr_arith !== exp_a || data_arith !== i[31:0]) bad_addr++;
            if (seen[addr_arith]) dup++;
            seen[addr_arith] = 1'b1;
            if (i < 2047 && busy !== 1'b1) bad_addr++;
            in_data = i[31:0] + 32'd1;
         end
         in_valid = 1'b0;
         chk("full.bad_writes", bad_addr, 32'd0);
         chk("full.dup_addr", dup, 32'd0);
         chk("full.done", {31'd0, done}, 32'd1);
         chk("full.words_written", {20'd0, words_written}, 32'd2048);
         chk("full.drop_err", {31'd0, drop_err}, 32'd0);
         @(posedge ram_clock);
         #1;
         chk("full.we_after", {31'd0, we_arith}, 32'd0);
      end

      // ---------------------------------------------------------------- reset mid-run
      idle_inputs();
      start = 1'b1; base_addr = 11'h055; length = 12'd5;
      @(posedge ram_clock);
      #1 idle_inputs();
      in_valid = 1'b1; in_data = 32'h5A5A0000;
      repeat (2) @(posedge ram_clock);
      #1;
      chk("rmid.pre_we", {31'd0, we_arith}, 32'd1);
      chk("rmid.pre_ww", {20'd0, words_written}, 32'd2);
      #2 reset = 1'b1;
      #1;
      chk_outputs("rmid.async", 0, 11'h0, 32'h0, 0, 0, 12'd0, 0);
      @(posedge ram_clock);
      #1;
      chk("rmid.we_next_edge", {31'd0, we_arith}, 32'd0);
      in_valid = 1'b0;
      reset = 1'b0;
      @(posedge ram_clock);
      #1;
      chk_outputs("rmid.after", 0, 11'h0, 32'h0, 0, 0, 12'd0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
